// File: rtl/vec_drain.sv
// vec_drain: accepts a W-bit request vector and serialises its set bits into
// a stream of binary indices, one per output beat. The order is highest index
// first, or lowest index first when FROM_LSB = 1. The final index is flagged.
module vec_drain #(
    parameter int W        = 8,
    parameter bit FROM_LSB = 1'b0,
    parameter int IDX_W    = $clog2(W)
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             i_in_vld,
    input  logic [W-1:0]     i_in_vec,
    output logic             o_in_rdy,
    output logic             o_out_vld,
    output logic [IDX_W-1:0] o_out_idx,
    output logic             o_out_last,
    input  logic             i_out_rdy,
    output logic             o_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_reg;
    logic [W-1:0]     res_reg;

    logic [IDX_W-1:0] sel_idx;
    logic [W-1:0]     sel_onehot;
    logic [W-1:0]     res_clr;
    logic             single_bit;
    logic             in_acc;
    logic             out_fire;

    // Priority pick of the residual: scan from the winning end and stop at
    // the first set bit. Produces both the binary index and the one-hot
    // mask that is used to clear that bit.
    always_comb begin
        int  b;
        logic found;
        sel_idx    = '0;
        sel_onehot = '0;
        found      = 1'b0;
        b          = 0;
        for (int i = 0; i < W; i++) begin
            b = FROM_LSB ? i : (W - 1 - i);
            if (!found && res_reg[b]) begin
                found         = 1'b1;
                sel_idx       = IDX_W'(b);
                sel_onehot[b] = 1'b1;
            end
        end
    end

    // Residual with the currently selected bit removed.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_clr
            assign res_clr[gi] = res_reg[gi] & ~sel_onehot[gi];
        end
    endgenerate

    // Exactly one bit left: nonzero, and clearing the lowest set bit empties it.
    assign single_bit = (res_reg != '0) && ((res_reg & (res_reg - W'(1))) == '0);

    assign in_acc   = i_in_vld  && (state_reg == IDLE);
    assign out_fire = i_out_rdy && (state_reg == DRAIN);

    // Outputs are decoded from state and the residual only, so nothing
    // combinationally depends on the handshake inputs.
    assign o_in_rdy   = (state_reg == IDLE);
    assign o_out_vld  = (state_reg == DRAIN);
    assign o_busy     = (state_reg == DRAIN);
    assign o_out_idx  = (state_reg == DRAIN) ? sel_idx : '0;
    assign o_out_last = (state_reg == DRAIN) && single_bit;

    // Control FSM and residual register. A zero vector is consumed in IDLE
    // and produces no output beat.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_reg <= IDLE;
            res_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_acc && (i_in_vec != '0)) begin
                        res_reg   <= i_in_vec;
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        res_reg <= res_clr;
                        if (single_bit) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    res_reg   <= '0;
                end
            endcase
        end
    end

    // A drain always has at least one bit left to emit.
    a_res_nonzero_in_drain : assert property (
        @(posedge clk) disable iff (!arst_n)
        (state_reg == DRAIN) |-> (res_reg != '0)
    );

endmodule
